// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-digit BCD stopwatch controller driven by two raw tact switches.
//
// Ports:
//   CLK      in   rising-edge system clock
//   RESET    in   asynchronous, active-low reset
//   START_SW in   raw switch, high = pressed; toggles run / pause
//   CLR_SW   in   raw switch, high = pressed; clears the count (lap toggle in RUN with lap build)
//   ONES     out  BCD units digit
//   TENS     out  BCD tens digit
//   STATE    out  0 = IDLE, 1 = RUN, 2 = PAUSE
//   RUNNING  out  high while STATE is RUN
//   CARRY    out  one-cycle pulse after the 99 -> 00 wrap
//
// Parameters: DEB_W (switch sample period 2^DEB_W cycles), TICK_DIV (cycles per count tick).
// Build option: define STOPWATCH_LAP_EN to enable the lap-hold display feature.

module stopwatch_ctrl #(
  parameter int unsigned DEB_W    = 19,
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START_SW,
  input  logic       CLR_SW,
  output logic [3:0] ONES,
  output logic [3:0] TENS,
  output logic [1:0] STATE,
  output logic       RUNNING,
  output logic       CARRY
);

  localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // ---------------------------------------------------------------------------
  // Switch sampling and press-edge detection
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] samp_cnt_q;
  logic             samp_en;
  logic             start_s_q, start_d_q, clr_s_q, clr_d_q;
  logic             armed_q;
  logic             start_pulse, clr_pulse;

  assign samp_en = (samp_cnt_q == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      samp_cnt_q <= '0;
      start_s_q  <= 1'b0;
      start_d_q  <= 1'b0;
      clr_s_q    <= 1'b0;
      clr_d_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      samp_cnt_q <= samp_cnt_q + DEB_W'(1);
      start_d_q  <= start_s_q;
      clr_d_q    <= clr_s_q;
      if (samp_en) begin
        start_s_q <= START_SW;
        clr_s_q   <= CLR_SW;
        armed_q   <= 1'b1;
        // First sample after reset loads both stages so a switch held through
        // reset release does not look like a fresh press.
        if (!armed_q) begin
          start_d_q <= START_SW;
          clr_d_q   <= CLR_SW;
        end
      end
    end
  end

  assign start_pulse = start_s_q & ~start_d_q;
  assign clr_pulse   = clr_s_q & ~clr_d_q;

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_pulse) state_d = ST_RUN;
      ST_RUN:   if (start_pulse) state_d = ST_PAUSE;
      ST_PAUSE: begin
        // Clear has priority over start while paused.
        if (clr_pulse)        state_d = ST_IDLE;
        else if (start_pulse) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Prescaler and BCD counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic          carry_q, carry_d;
  logic          tick;

  assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);

  always_comb begin
    pre_d   = pre_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (state_d == ST_IDLE) begin
      // Entering or sitting in IDLE clears everything on the same edge.
      pre_d  = '0;
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        pre_d = '0;
        if (ones_q >= 4'd9) begin
          ones_d = 4'd0;
          if (tens_q >= 4'd9) begin
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre_q   <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display selection
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  logic       lap_q;
  logic [3:0] lap_ones_q, lap_tens_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lap_q      <= 1'b0;
      lap_ones_q <= 4'd0;
      lap_tens_q <= 4'd0;
    end else if (state_d == ST_IDLE) begin
      lap_q <= 1'b0;
    end else if ((state_q == ST_RUN) && clr_pulse && !start_pulse) begin
      lap_q      <= ~lap_q;
      lap_ones_q <= ones_q;
      lap_tens_q <= tens_q;
    end
  end

  assign ONES = lap_q ? lap_ones_q : ones_q;
  assign TENS = lap_q ? lap_tens_q : tens_q;
`else
  assign ONES = ones_q;
  assign TENS = tens_q;
`endif

  assign STATE   = state_q;
  assign RUNNING = (state_q == ST_RUN);
  assign CARRY   = carry_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl (DEB_W=2, TICK_DIV=4).
// A small reference model counts run cycles and derives the expected digits and carry.

module tb_stopwatch_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START_SW;
  logic       CLR_SW;
  logic [3:0] ONES;
  logic [3:0] TENS;
  logic [1:0] STATE;
  logic       RUNNING;
  logic       CARRY;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(
    .DEB_W   (2),
    .TICK_DIV(4)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START_SW(START_SW),
    .CLR_SW  (CLR_SW),
    .ONES    (ONES),
    .TENS    (TENS),
    .STATE   (STATE),
    .RUNNING (RUNNING),
    .CARRY   (CARRY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: one count tick per 4 clock edges spent in RUN.
  int   run_edges;
  logic exp_carry;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      run_edges <= 0;
      exp_carry <= 1'b0;
    end else if (STATE == 2'd1) begin
      run_edges <= run_edges + 1;
      exp_carry <= ((run_edges + 1) % 400) == 0;
    end else begin
      if (STATE == 2'd0) run_edges <= 0;
      exp_carry <= 1'b0;
    end
  end

  function automatic int exp_ones();
    return (run_edges / 4) % 10;
  endfunction

  function automatic int exp_tens();
    return (run_edges / 40) % 10;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_live(input string tag);
    check_eq({tag, "_ones"}, ONES, exp_ones());
    check_eq({tag, "_tens"}, TENS, exp_tens());
    check_eq({tag, "_carry"}, CARRY, exp_carry);
  endtask

  // Hold the given switches until STATE reaches want (bounded), then release.
  task automatic press(input logic s, input logic c, input logic [1:0] want, input string tag);
    int n = 0;
    START_SW = s;
    CLR_SW   = c;
    while (STATE != want && n < 12) begin
      @(negedge CLK);
      n++;
    end
    check_eq(tag, STATE, want);
    repeat (6) @(negedge CLK);
    START_SW = 1'b0;
    CLR_SW   = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    int n;
    int carry_cnt;
    int carry_at;
    int disp;
    RESET    = 1'b0;
    START_SW = 1'b0;
    CLR_SW   = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check_eq("rst_ones", ONES, 0);
    check_eq("rst_tens", TENS, 0);
    check_eq("rst_state", STATE, 0);
    check_eq("rst_running", RUNNING, 0);
    check_eq("rst_carry", CARRY, 0);
    RESET = 1'b1;
    repeat (8) @(negedge CLK);

    // Start from reset, then 40 cycles gives ten ticks
    START_SW = 1'b1;
    n = 0;
    while (STATE != 2'd1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check_eq("start_state", STATE, 1);
    check_eq("start_running", RUNNING, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (n + i >= 12) START_SW = 1'b0;
    end
    START_SW = 1'b0;
    check_eq("t40_tens", TENS, 1);
    check_eq("t40_ones", ONES, 0);

    // 400 more cycles: wrap 99 -> 00 with one carry pulse
    carry_cnt = 0;
    carry_at  = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge CLK);
      if (CARRY === 1'b1) begin
        carry_cnt++;
        carry_at = i;
        check_eq("wrap_ones", ONES, 0);
        check_eq("wrap_tens", TENS, 0);
      end
    end
    check_eq("carry_count", carry_cnt, 1);
    check_eq("carry_pos", carry_at, 360);
    check_live("after_wrap");

    // Pause freezes, resume continues from the held prescaler
    press(1'b1, 1'b0, 2'd2, "pause");
    check_eq("pause_running", RUNNING, 0);
    repeat (100) @(negedge CLK);
    check_live("frozen");
    press(1'b1, 1'b0, 2'd1, "resume");
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check_live("resumed");
    end
    press(1'b1, 1'b0, 2'd2, "pause2");
    press(1'b0, 1'b1, 2'd0, "clr_pause");
    check_eq("clr_ones", ONES, 0);
    check_eq("clr_tens", TENS, 0);
    press(1'b0, 1'b1, 2'd0, "clr_idle");

    // Simultaneous presses
    press(1'b1, 1'b0, 2'd1, "run3");
    press(1'b1, 1'b0, 2'd2, "pause3");
    press(1'b1, 1'b1, 2'd0, "both_pause");
    press(1'b1, 1'b0, 2'd1, "run4");
    press(1'b1, 1'b1, 2'd2, "both_run");
    press(1'b1, 1'b0, 2'd1, "run5");

    // Asynchronous reset at count 37
    n = 0;
    while (!(exp_ones() == 7 && exp_tens() == 3) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check_eq("reach37", (exp_ones() == 7 && exp_tens() == 3), 1);
    check_eq("at37_ones", ONES, 7);
    check_eq("at37_tens", TENS, 3);
    RESET = 1'b0;
    #1;
    check_eq("arst_ones", ONES, 0);
    check_eq("arst_tens", TENS, 0);
    check_eq("arst_state", STATE, 0);
    check_eq("arst_running", RUNNING, 0);
    check_eq("arst_carry", CARRY, 0);
    START_SW = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (20) @(negedge CLK);
    check_eq("held_start", STATE, 0);
    START_SW = 1'b0;
    repeat (8) @(negedge CLK);
    press(1'b1, 1'b0, 2'd1, "fresh_press");

    // Clear in RUN at count 12: lap hold or ignored
    n = 0;
    while (!(exp_ones() == 2 && exp_tens() == 1) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check_eq("reach12", (exp_ones() == 2 && exp_tens() == 1), 1);
    press(1'b0, 1'b1, 2'd1, "clr_run");
`ifdef STOPWATCH_LAP_EN
    disp = TENS * 10 + ONES;
    check_eq("lap_hold", (disp == 12 || disp == 13), 1);
    repeat (40) @(negedge CLK);
    disp = TENS * 10 + ONES;
    check_eq("lap_hold_late", (disp == 12 || disp == 13), 1);
    check_eq("lap_live_moved", (exp_tens() * 10 + exp_ones()) >= 22, 1);
    press(1'b0, 1'b1, 2'd1, "lap_release");
    check_live("lap_off");
`else
    disp = TENS * 10 + ONES;
    check_eq("nolap_live", disp, exp_tens() * 10 + exp_ones());
    repeat (40) @(negedge CLK);
    check_live("nolap_late");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEB_W, default 19, width of the free-running switch-sampling counter; switches are sampled once every 2^DEB_W cycles.
REQ-002 Parameter TICK_DIV, default 5000000, number of CLK cycles per count tick; legal range 2 to 2^24.
REQ-003 CLK  input  1  rising-edge system clock.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 START_SW  input  1  raw tact switch, high = pressed; toggles run and pause.
REQ-006 CLR_SW  input  1  raw tact switch, high = pressed; clears the count (and takes a lap when LAP_EN is defined).
REQ-007 ONES  output  4  BCD units digit, 0-9.
REQ-008 TENS  output  4  BCD tens digit, 0-9.
REQ-009 STATE  output  2  controller state: IDLE=0, RUN=1, PAUSE=2; 3 is never driven.
REQ-010 RUNNING  output  1  high exactly when STATE==RUN.
REQ-011 CARRY  output  1  one-cycle pulse on wrap from 99 to 00.

Function
REQ-012 A DEB_W-bit sample counter SHALL increment every cycle and wrap; each switch SHALL be registered only in cycles where the counter equals 0.
REQ-013 Each sampled switch SHALL be delayed one further register; its press pulse SHALL be sampled AND NOT delayed, high for exactly one cycle per press.
REQ-014 Transitions on start pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-015 Transitions on clear pulse: PAUSE->IDLE, IDLE->IDLE; in RUN the clear pulse SHALL be ignored (see REQ-027).
REQ-016 Simultaneous start and clear pulses: in IDLE or RUN start wins; in PAUSE clear wins, giving IDLE.
REQ-017 The state register SHALL update on the edge where the pulse is high; STATE/RUNNING change in the following cycle.
REQ-018 The prescaler (ceil(log2 TICK_DIV) bits) SHALL count only in RUN, hold in PAUSE, and be 0 in IDLE.
REQ-019 A tick SHALL occur when prescaler==TICK_DIV-1 in RUN; the prescaler then returns to 0. This gives exactly TICK_DIV cycles per tick.
REQ-020 On a tick, ONES SHALL increment. At ONES==9, ONES SHALL go to 0 and TENS SHALL increment. At TENS==9 and ONES==9, both SHALL go to 0 and CARRY SHALL pulse for one cycle.
REQ-021 Entering IDLE SHALL zero ONES, TENS and the prescaler in the same edge.
REQ-022 ONES and TENS SHALL never hold values 10-15.

Reset
REQ-023 While RESET==0, all of the following SHALL be held at 0: sample counter, switch samples and delay registers, prescaler, ONES, TENS and CARRY. The FSM SHALL be held in IDLE.
REQ-024 Reset asserted mid-RUN SHALL take effect immediately without waiting for CLK. No press pulse SHALL be generated on release of reset.

Configuration
REQ-025 Macro STOPWATCH_LAP_EN SHALL select the lap-hold feature.
REQ-026 With the macro undefined, ONES and TENS SHALL always show the live count, and CLR_SW in RUN SHALL have no effect.
REQ-027 With the macro defined, a clear pulse in RUN SHALL toggle a lap flag:
- flag set: ONES/TENS show the values latched at that edge while the live count continues;
- flag clear: the live count is shown again;
- the flag SHALL clear on entry to IDLE and on reset;
- there SHALL be no new ports.

Verification (DEB_W=2, TICK_DIV=4)
REQ-028 Press START for 12 cycles from reset -> STATE=1 and RUNNING=1 within 10 cycles; after a further 40 cycles -> TENS=1, ONES=0.
REQ-029 Run 400 cycles from 00 -> ONES/TENS return to 0/0; CARRY high for exactly one cycle, in the cycle after the 99->00 tick edge.
REQ-030 In RUN, press START -> STATE=2, count frozen for 100 cycles; press START again -> STATE=1 and counting resumes from the frozen prescaler value. Then press START, then CLR -> STATE=0, ONES=TENS=0.
REQ-031 In PAUSE, press START and CLR together -> STATE=0. In RUN, press both together -> STATE=2.
REQ-032 Drop RESET at count 37 in RUN -> all outputs 0 and STATE=0 before the next CLK edge. Then release RESET with START held -> no transition until a fresh press edge is sampled.
REQ-033 With STOPWATCH_LAP_EN defined, press CLR in RUN at count 12 -> outputs stay at 12 while the internal count advances. Press CLR again -> the live count is shown. Without the macro, the same stimulus leaves the outputs live.
